decode_stage: RTL



---
 rtl/decode_pkg.sv | 80 ++++++++
 rtl/decode_if.sv | 41 ++++
 rtl/decode_fields.sv | 59 +++++
 rtl/decode_stage.sv | 101 ++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared MIPS-I decode types, encodings and legality helpers.
package decode_pkg;

  // Record members are sized for the widest supported datapath; narrower
  // configurations leave the upper bits at zero.
  localparam int unsigned DATA_W_MAX = 64;

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_BEQ     = 6'd4;
  localparam logic [5:0] OP_BNE     = 6'd5;
  localparam logic [5:0] OP_ADDI    = 6'd8;
  localparam logic [5:0] OP_ADDIU   = 6'd9;
  localparam logic [5:0] OP_SLTI    = 6'd10;
  localparam logic [5:0] OP_SLTIU   = 6'd11;
  localparam logic [5:0] OP_ANDI    = 6'd12;
  localparam logic [5:0] OP_ORI     = 6'd13;
  localparam logic [5:0] OP_XORI    = 6'd14;
  localparam logic [5:0] OP_LUI     = 6'd15;
  localparam logic [5:0] OP_LB      = 6'd32;
  localparam logic [5:0] OP_LW      = 6'd35;
  localparam logic [5:0] OP_SB      = 6'd40;
  localparam logic [5:0] OP_SW      = 6'd43;

  localparam logic [5:0] F_SLL  = 6'd0;
  localparam logic [5:0] F_SRL  = 6'd2;
  localparam logic [5:0] F_SRA  = 6'd3;
  localparam logic [5:0] F_JR   = 6'd8;
  localparam logic [5:0] F_JALR = 6'd9;
  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_ADDU = 6'd33;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [5:0] F_SUBU = 6'd35;
  localparam logic [5:0] F_AND  = 6'd36;
  localparam logic [5:0] F_OR   = 6'd37;
  localparam logic [5:0] F_XOR  = 6'd38;
  localparam logic [5:0] F_NOR  = 6'd39;
  localparam logic [5:0] F_SLT  = 6'd42;
  localparam logic [5:0] F_SLTU = 6'd43;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_J = 2'd2
  } fmt_e;

  typedef struct packed {
    logic [5:0]            opcode;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [4:0]            shamt;
    logic [5:0]            funct;
    logic [15:0]           imm;
    logic [25:0]           addr;
    fmt_e                  fmt;
    logic                  illegal;
    logic [DATA_W_MAX-1:0] imm_ext;
    logic [DATA_W_MAX-1:0] jaddr;
    logic [DATA_W_MAX-1:0] pc;
  } decoded_t;

  function automatic logic legal_opcode(input logic [5:0] op);
    case (op)
      OP_SPECIAL, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LB, OP_LW, OP_SB, OP_SW: legal_opcode = 1'b1;
      default: legal_opcode = 1'b0;
    endcase
  endfunction

  function automatic logic legal_funct(input logic [5:0] fn);
    case (fn)
      F_SLL, F_SRL, F_SRA, F_JR, F_JALR, F_ADD, F_ADDU, F_SUB, F_SUBU,
      F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: legal_funct = 1'b1;
      default: legal_funct = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-side and register-read-side signals of the decode stage.
interface decode_if import decode_pkg::*; #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [DATA_W-1:0] in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_opcode;
  logic [4:0]        out_rs;
  logic [4:0]        out_rt;
  logic [4:0]        out_rd;
  logic [4:0]        out_shamt;
  logic [5:0]        out_funct;
  logic [15:0]       out_imm;
  logic [25:0]       out_addr;
  fmt_e              out_fmt;
  logic [DATA_W-1:0] out_imm_ext;
  logic [DATA_W-1:0] out_jaddr;
  logic              out_illegal;
  logic [DATA_W-1:0] out_pc;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct,
           out_imm, out_addr, out_fmt, out_imm_ext, out_jaddr, out_illegal, out_pc, count
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct,
           out_imm, out_addr, out_fmt, out_imm_ext, out_jaddr, out_illegal, out_pc, count
  );
endinterface

// File: rtl/decode_fields.sv
// Combinational split of one instruction word into a decoded record.
module decode_fields import decode_pkg::*; #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [31:0]       i_instr,
  input  logic [DATA_W-1:0] i_pc,
  output decoded_t          o_dec
);
  logic [5:0]         w_opcode;
  logic [5:0]         w_funct;
  logic [15:0]        w_imm;
  logic [31:0]        w_lui;
  logic [DATA_W-1:0]  w_imm_ext;
  logic [DATA_W-29:0] w_seg;
  logic [DATA_W-1:0]  w_jaddr;

  assign w_opcode = i_instr[31:26];
  assign w_funct  = i_instr[5:0];
  assign w_imm    = i_instr[15:0];
  assign w_lui    = {w_imm, 16'h0000};

  // Segment of pc+4: the +4 carries into bit 28 only when bits 27:2 are all ones.
  assign w_seg   = i_pc[DATA_W-1:28] + (DATA_W-28)'(&i_pc[27:2]);
  assign w_jaddr = {w_seg, i_instr[25:0], 2'b00};

  // Logical immediates zero-extend, lui shifts up, everything else sign-extends.
  always_comb begin
    case (w_opcode)
      OP_ANDI, OP_ORI, OP_XORI: w_imm_ext = DATA_W'(w_imm);
      OP_LUI:                   w_imm_ext = DATA_W'($signed(w_lui));
      default:                  w_imm_ext = DATA_W'($signed(w_imm));
    endcase
  end

  // Assemble the record; fields are reported even for illegal encodings.
  always_comb begin
    o_dec         = '0;
    o_dec.opcode  = w_opcode;
    o_dec.rs      = i_instr[25:21];
    o_dec.rt      = i_instr[20:16];
    o_dec.rd      = i_instr[15:11];
    o_dec.shamt   = i_instr[10:6];
    o_dec.funct   = w_funct;
    o_dec.imm     = w_imm;
    o_dec.addr    = i_instr[25:0];
    if (w_opcode == OP_SPECIAL) begin
      o_dec.fmt = FMT_R;
    end else if (w_opcode == OP_J || w_opcode == OP_JAL) begin
      o_dec.fmt = FMT_J;
    end else begin
      o_dec.fmt = FMT_I;
    end
    o_dec.illegal = !legal_opcode(w_opcode) ||
                    ((w_opcode == OP_SPECIAL) && !legal_funct(w_funct));
    o_dec.imm_ext = DATA_W_MAX'(w_imm_ext);
    o_dec.jaddr   = DATA_W_MAX'(w_jaddr);
    o_dec.pc      = DATA_W_MAX'(i_pc);
  end
endmodule

// File: rtl/decode_stage.sv
// Buffered decode stage: decode at the input, queue records in a DEPTH-entry FIFO.
module decode_stage import decode_pkg::*; #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input logic   clk,
  input logic   rst_n,
  decode_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  decoded_t         w_dec;
  decoded_t         w_head;
  decoded_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, w_wptr_nxt;
  logic [PTR_W-1:0] r_rptr, w_rptr_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             w_full, w_empty, w_push, w_pop;

  decode_fields #(.DATA_W(DATA_W)) u_fields (
    .i_instr (bus.in_instr),
    .i_pc    (bus.in_pc),
    .o_dec   (w_dec)
  );

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  // flush wins over both handshakes in the same cycle.
  assign w_push  = bus.in_valid && !w_full && !bus.flush;
  assign w_pop   = !w_empty && bus.out_ready && !bus.flush;

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    w_count_nxt = r_count;
    if (bus.flush) begin
      w_wptr_nxt  = '0;
      w_rptr_nxt  = '0;
      w_count_nxt = '0;
    end else begin
      if (w_push) w_wptr_nxt = r_wptr + PTR_W'(1);
      if (w_pop)  w_rptr_nxt = r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Record storage; cleared on reset so an idle stage presents all-zero fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= w_dec;
    end
  end

  assign w_head = r_mem[r_rptr];

  assign bus.in_ready    = !w_full;
  assign bus.out_valid   = !w_empty;
  assign bus.out_opcode  = w_head.opcode;
  assign bus.out_rs      = w_head.rs;
  assign bus.out_rt      = w_head.rt;
  assign bus.out_rd      = w_head.rd;
  assign bus.out_shamt   = w_head.shamt;
  assign bus.out_funct   = w_head.funct;
  assign bus.out_imm     = w_head.imm;
  assign bus.out_addr    = w_head.addr;
  assign bus.out_fmt     = w_head.fmt;
  assign bus.out_illegal = w_head.illegal;
  assign bus.out_imm_ext = w_head.imm_ext[DATA_W-1:0];
  assign bus.out_jaddr   = w_head.jaddr[DATA_W-1:0];
  assign bus.out_pc      = w_head.pc[DATA_W-1:0];
  assign bus.count       = r_count;

  // Upper record bits are constant zero at narrower widths.
  if (DATA_W < DATA_W_MAX) begin : g_trim
    logic w_unused_hi;
    assign w_unused_hi = ^{w_head.imm_ext[DATA_W_MAX-1:DATA_W],
                           w_head.jaddr[DATA_W_MAX-1:DATA_W],
                           w_head.pc[DATA_W_MAX-1:DATA_W]};
  end
endmodule
